// File: rtl/vga_hvsync_generator.sv
// VGA raster timing generator (default 640x480 @ ~60 Hz).
// Free-running pixel/line counters with registered hsync/vsync and a
// combinational display-active flag.
// Optional feature macro: HVSYNC_NEG_POLARITY_EN -- when defined, hsync and
// vsync are active-low (idle/reset level 1); otherwise active-high (idle 0).
module vga_hvsync_generator #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_BOTTOM  = 10,
  parameter int V_SYNC    = 2,
  parameter int V_TOP     = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [9:0] hpos,
  output logic [9:0] vpos
);

  // Timing landmarks, pre-sized to the counter width so compares are exact.
  localparam logic [9:0] H_DISPLAY_V    = 10'(H_DISPLAY);
  localparam logic [9:0] H_MAX_V        = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] H_SYNC_START_V = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] H_SYNC_END_V   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_DISPLAY_V    = 10'(V_DISPLAY);
  localparam logic [9:0] V_MAX_V        = 10'(V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1);
  localparam logic [9:0] V_SYNC_START_V = 10'(V_DISPLAY + V_BOTTOM);
  localparam logic [9:0] V_SYNC_END_V   = 10'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

  // Level driven onto a sync output while its pulse is active.
`ifdef HVSYNC_NEG_POLARITY_EN
  localparam logic SYNC_ACTIVE = 1'b0;
`else
  localparam logic SYNC_ACTIVE = 1'b1;
`endif
  localparam logic SYNC_IDLE = ~SYNC_ACTIVE;

  logic [9:0] hpos_r;
  logic [9:0] vpos_r;
  logic       hsync_r;
  logic       vsync_r;
  logic       h_end_s;
  logic       v_end_s;
  logic       h_zone_s;
  logic       v_zone_s;

  // Inclusive window test shared by both sync decoders.
  function automatic logic in_window(input logic [9:0] pos,
                                     input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (pos >= lo) && (pos <= hi);
  endfunction

  assign h_end_s  = (hpos_r == H_MAX_V);
  assign v_end_s  = (vpos_r == V_MAX_V);
  assign h_zone_s = in_window(hpos_r, H_SYNC_START_V, H_SYNC_END_V);
  assign v_zone_s = in_window(vpos_r, V_SYNC_START_V, V_SYNC_END_V);

  // Pixel counter: advances every clock, wraps at the end of the line.
  always_ff @(posedge clk) begin
    if (reset) begin
      hpos_r <= 10'd0;
    end else if (h_end_s) begin
      hpos_r <= 10'd0;
    end else begin
      hpos_r <= hpos_r + 10'd1;
    end
  end

  // Line counter: advances on the last pixel of each line, wraps at frame end.
  always_ff @(posedge clk) begin
    if (reset) begin
      vpos_r <= 10'd0;
    end else if (h_end_s) begin
      if (v_end_s) begin
        vpos_r <= 10'd0;
      end else begin
        vpos_r <= vpos_r + 10'd1;
      end
    end else begin
      vpos_r <= vpos_r;
    end
  end

  // Sync registers sample the pre-increment position, giving a one-clock lag.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_r <= SYNC_IDLE;
      vsync_r <= SYNC_IDLE;
    end else begin
      hsync_r <= h_zone_s ? SYNC_ACTIVE : SYNC_IDLE;
      vsync_r <= v_zone_s ? SYNC_ACTIVE : SYNC_IDLE;
    end
  end

  assign hpos       = hpos_r;
  assign vpos       = vpos_r;
  assign hsync      = hsync_r;
  assign vsync      = vsync_r;
  // Visible-area flag has no lag relative to the counters.
  assign display_on = (hpos_r < H_DISPLAY_V) && (vpos_r < V_DISPLAY_V);

endmodule

// File: tb/tb_vga_hvsync_generator.sv
// Self-checking bench for vga_hvsync_generator.
// Two instances: full 640x480 timing for line-level behaviour and a
// shrunken raster so whole frames (and random resets) fit in a short run.
// The reference model derives every output from the clocks elapsed since reset.
module tb_vga_hvsync_generator;

`ifdef HVSYNC_NEG_POLARITY_EN
  localparam logic ACT = 1'b0;
`else
  localparam logic ACT = 1'b1;
`endif

  // Full-size raster.
  localparam int A_HD = 640, A_HF = 16, A_HS = 96, A_HB = 48;
  localparam int A_VD = 480, A_VB = 10, A_VS = 2,  A_VT = 33;
  localparam int A_HTOT = A_HD + A_HF + A_HS + A_HB;   // 800
  localparam int A_VTOT = A_VD + A_VB + A_VS + A_VT;   // 525
  // Shrunken raster.
  localparam int B_HD = 20, B_HF = 3, B_HS = 5, B_HB = 4;
  localparam int B_VD = 10, B_VB = 2, B_VS = 3, B_VT = 2;
  localparam int B_HTOT = B_HD + B_HF + B_HS + B_HB;   // 32
  localparam int B_VTOT = B_VD + B_VB + B_VS + B_VT;   // 17

  localparam int NCYC = 20000;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic       hs_a, vs_a, de_a, hs_b, vs_b, de_b;
  logic [9:0] hp_a, vp_a, hp_b, vp_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vga_hvsync_generator u_dut_full (
    .clk(clk), .reset(rst_a), .hsync(hs_a), .vsync(vs_a),
    .display_on(de_a), .hpos(hp_a), .vpos(vp_a)
  );

  vga_hvsync_generator #(
    .H_DISPLAY(B_HD), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
    .V_DISPLAY(B_VD), .V_BOTTOM(B_VB), .V_SYNC(B_VS), .V_TOP(B_VT)
  ) u_dut_small (
    .clk(clk), .reset(rst_b), .hsync(hs_b), .vsync(vs_b),
    .display_on(de_b), .hpos(hp_b), .vpos(vp_b)
  );

  // Count one comparison and report it if it does not hold.
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Column after t clocks since reset.
  function automatic int m_hpos(input longint t, input int htot);
    return int'(t % htot);
  endfunction

  // Line after t clocks since reset.
  function automatic int m_vpos(input longint t, input int htot, input int vtot);
    return int'((t / htot) % vtot);
  endfunction

  // Sync output level: active when the position one clock earlier was in the pulse window.
  function automatic logic m_sync(input longint t, input int htot, input int vtot,
                                  input bit is_v, input int start, input int len);
    longint idx;
    bit     act;
    if (t < 1) begin
      act = 1'b0;
    end else begin
      idx = is_v ? (((t - 1) / htot) % vtot) : ((t - 1) % htot);
      act = (idx >= start) && (idx < start + len);
    end
    return act ? ACT : ~ACT;
  endfunction

  longint t_a, t_b;
  int     run_a, run_b;
  bit     dir_done;

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    t_a = 0; t_b = 0;
    run_a = 0; run_b = 0;
    dir_done = 1'b0;
    repeat (2) @(posedge clk);

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      // Compare both instances against the arithmetic model.
      check_val("a_hpos",  32'(hp_a), 32'(m_hpos(t_a, A_HTOT)));
      check_val("a_vpos",  32'(vp_a), 32'(m_vpos(t_a, A_HTOT, A_VTOT)));
      check_val("a_hsync", 32'(hs_a), 32'(m_sync(t_a, A_HTOT, A_VTOT, 1'b0, A_HD + A_HF, A_HS)));
      check_val("a_vsync", 32'(vs_a), 32'(m_sync(t_a, A_HTOT, A_VTOT, 1'b1, A_VD + A_VB, A_VS)));
      check_val("a_disp",  32'(de_a), 32'((m_hpos(t_a, A_HTOT) < A_HD) &&
                                          (m_vpos(t_a, A_HTOT, A_VTOT) < A_VD)));
      check_val("b_hpos",  32'(hp_b), 32'(m_hpos(t_b, B_HTOT)));
      check_val("b_vpos",  32'(vp_b), 32'(m_vpos(t_b, B_HTOT, B_VTOT)));
      check_val("b_hsync", 32'(hs_b), 32'(m_sync(t_b, B_HTOT, B_VTOT, 1'b0, B_HD + B_HF, B_HS)));
      check_val("b_vsync", 32'(vs_b), 32'(m_sync(t_b, B_HTOT, B_VTOT, 1'b1, B_VD + B_VB, B_VS)));
      check_val("b_disp",  32'(de_b), 32'((m_hpos(t_b, B_HTOT) < B_HD) &&
                                          (m_vpos(t_b, B_HTOT, B_VTOT) < B_VD)));

      // Full-size hsync: rises 657 clocks into a line, lasts exactly 96 clocks.
      if (hs_a == ACT) begin
        if (run_a == 0) check_val("a_hsync_rise", 32'(m_hpos(t_a, A_HTOT)), 32'(A_HD + A_HF + 1));
        run_a++;
      end else begin
        if (run_a > 0) check_val("a_hsync_width", 32'(run_a), 32'(A_HS));
        run_a = 0;
      end
      // Small-raster vsync: rises at V_SYNC_START*HTOT+1 after reset, lasts V_SYNC lines.
      if (vs_b == ACT) begin
        if (run_b == 0) check_val("b_vsync_rise", 32'(t_b % (B_HTOT * B_VTOT)),
                                  32'((B_VD + B_VB) * B_HTOT + 1));
        run_b++;
      end else begin
        if (run_b > 0) check_val("b_vsync_width", 32'(run_b), 32'(B_VS * B_HTOT));
        run_b = 0;
      end

      // Reset choices for the coming edge: one directed mid-line reset, then random ones.
      if (!dir_done && t_a == longint'(2 * A_HTOT + 300)) begin
        check_val("a_pre_reset_hpos", 32'(hp_a), 32'd300);
        rst_a = 1'b1;
        dir_done = 1'b1;
      end else if (cyc > 8000 && $urandom_range(0, 4999) == 0) begin
        rst_a = 1'b1;
      end else begin
        rst_a = 1'b0;
      end
      rst_b = (cyc > 1200 && $urandom_range(0, 299) == 0) ? 1'b1 : 1'b0;

      @(posedge clk);
      if (rst_a) begin
        t_a = 0;
        run_a = 0;
      end else begin
        t_a++;
      end
      if (rst_b) begin
        t_b = 0;
        run_b = 0;
      end else begin
        t_b++;
      end
    end

    check_val("directed_reset_seen", 32'(dir_done), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
